alu_issue_sequencer: RTL

Front-end sequencer that drives the datapath ALU's operand/select port and collects its result. Accepts one decoded-register MIPS instruction (instruction word plus rs/rt register values) through a valid/ready handshake. Generates the 4-bit ALU select and the 32-bit X/Y operands, and waits a per-operation latency so multi-cycle MUL/DIV paths settle. Captures result and zero flag, resolves BEQ/BNE, and presents the outcome downstream through a second valid/ready handshake. Sits between the register-read stage and the writeback/branch logic.

---
 rtl/alu_issue_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: decodes one MIPS instruction, drives the ALU operand/select
// port, waits the per-op latency, then captures the ALU result and branch outcome.
// Ports: in_* valid/ready instruction intake, alu_* ALU drive/return, out_* result
// handshake held until out_ready.
module alu_issue_sequencer #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_res,
  input  logic        alu_zf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zf,
  output logic        out_branch_taken,
  output logic        out_illegal,
  output logic        out_div0
);

  localparam int CW = 16;

  localparam logic [3:0] SEL_ADD = 4'b0000;
  localparam logic [3:0] SEL_SUB = 4'b0001;
  localparam logic [3:0] SEL_MUL = 4'b0010;
  localparam logic [3:0] SEL_DIV = 4'b0011;
  localparam logic [3:0] SEL_AND = 4'b0100;
  localparam logic [3:0] SEL_OR  = 4'b0101;
  localparam logic [3:0] SEL_NOR = 4'b0110;
  localparam logic [3:0] SEL_NOP = 4'b0111;
  localparam logic [3:0] SEL_SLT = 4'b1001;
  localparam logic [3:0] SEL_XOR = 4'b1010;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     alu_x_q, alu_x_d;
  logic [31:0]     alu_y_q, alu_y_d;
  logic [3:0]      alu_sel_q, alu_sel_d;
  logic            beq_q, beq_d;
  logic            bne_q, bne_d;
  logic            ill_q, ill_d;
  logic            div0_q, div0_d;
  logic [31:0]     res_q, res_d;
  logic            zf_q, zf_d;
  logic            taken_q, taken_d;

  // ---------------- instruction decode ----------------
  logic [5:0]    op, funct;
  logic [31:0]   simm, zimm;
  logic [3:0]    dec_sel;
  logic [31:0]   dec_y;
  logic          dec_ill, dec_beq, dec_bne, dec_div0;
  logic [CW-1:0] dec_lat;
  logic          unused_fields;

  assign op            = in_instr[31:26];
  assign funct         = in_instr[5:0];
  assign simm          = {{16{in_instr[15]}}, in_instr[15:0]};
  assign zimm          = {16'h0000, in_instr[15:0]};
  // Register numbers are resolved upstream; only the values are used here.
  assign unused_fields = ^in_instr[25:16];

  always_comb begin
    dec_sel = SEL_NOP;
    dec_y   = in_rt_data;
    dec_ill = 1'b0;
    dec_beq = 1'b0;
    dec_bne = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: dec_sel = SEL_ADD;
          6'h22, 6'h23: dec_sel = SEL_SUB;
          6'h18:        dec_sel = SEL_MUL;
          6'h1A:        dec_sel = SEL_DIV;
          6'h24:        dec_sel = SEL_AND;
          6'h25:        dec_sel = SEL_OR;
          6'h26:        dec_sel = SEL_XOR;
          6'h27:        dec_sel = SEL_NOR;
          6'h2A:        dec_sel = SEL_SLT;
          default:      dec_ill = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: begin dec_sel = SEL_ADD; dec_y = simm; end
      6'h0A:                      begin dec_sel = SEL_SLT; dec_y = simm; end
      6'h0C:                      begin dec_sel = SEL_AND; dec_y = zimm; end
      6'h0D:                      begin dec_sel = SEL_OR;  dec_y = zimm; end
      6'h0E:                      begin dec_sel = SEL_XOR; dec_y = zimm; end
      6'h04:                      begin dec_sel = SEL_SUB; dec_beq = 1'b1; end
      6'h05:                      begin dec_sel = SEL_SUB; dec_bne = 1'b1; end
      default:                    dec_ill = 1'b1;
    endcase
  end

  assign dec_div0 = (dec_sel == SEL_DIV) && (in_rt_data == 32'h0);

  always_comb begin
    dec_lat = CW'(1);
    if (dec_sel == SEL_MUL)      dec_lat = CW'(MUL_LAT);
    else if (dec_sel == SEL_DIV) dec_lat = CW'(DIV_LAT);
  end

  // ---------------- sequencing ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_x_d   = alu_x_q;
    alu_y_d   = alu_y_q;
    alu_sel_d = alu_sel_q;
    beq_d     = beq_q;
    bne_d     = bne_q;
    ill_d     = ill_q;
    div0_d    = div0_q;
    res_d     = res_q;
    zf_d      = zf_q;
    taken_d   = taken_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = EXEC;
          cnt_d     = dec_lat;
          alu_x_d   = in_rs_data;
          alu_y_d   = dec_y;
          alu_sel_d = dec_sel;
          beq_d     = dec_beq;
          bne_d     = dec_bne;
          ill_d     = dec_ill;
          div0_d    = dec_div0;
        end
      end
      EXEC: begin
        // Counter runs L..0; sampling at 0 gives the ALU one cycle to see the
        // freshly registered operands plus L full cycles of settle time.
        if (cnt_q == '0) begin
          state_d = DONE;
          if (ill_q) begin
            res_d = 32'h0;
            zf_d  = alu_zf;
          end else if (div0_q) begin
            res_d = 32'hFFFF_FFFF;
            zf_d  = 1'b0;
          end else begin
            res_d = alu_res;
            zf_d  = alu_zf;
          end
          taken_d = (beq_q & alu_zf) | (bne_q & ~alu_zf);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      alu_x_q   <= 32'h0;
      alu_y_q   <= 32'h0;
      alu_sel_q <= SEL_NOP;
      beq_q     <= 1'b0;
      bne_q     <= 1'b0;
      ill_q     <= 1'b0;
      div0_q    <= 1'b0;
      res_q     <= 32'h0;
      zf_q      <= 1'b0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_x_q   <= alu_x_d;
      alu_y_q   <= alu_y_d;
      alu_sel_q <= alu_sel_d;
      beq_q     <= beq_d;
      bne_q     <= bne_d;
      ill_q     <= ill_d;
      div0_q    <= div0_d;
      res_q     <= res_d;
      zf_q      <= zf_d;
      taken_q   <= taken_d;
    end
  end

  assign in_ready         = (state_q == IDLE);
  assign out_valid        = (state_q == DONE);
  assign alu_x            = alu_x_q;
  assign alu_y            = alu_y_q;
  assign alu_sel          = alu_sel_q;
  assign out_result       = res_q;
  assign out_zf           = zf_q;
  assign out_branch_taken = taken_q;
  assign out_illegal      = ill_q;
  assign out_div0         = div0_q;

endmodule
